pc_gen: RTL

Parametrised program-counter generator for the fetch stage; successor to the plain enable-gated PC register. Computes and registers the next fetch address from the trap, branch-redirect, return-prediction and sequential sources under a fixed priority. Holds a redirect that arrives during a stall until the stall clears, and keeps a small return-address stack (RAS) for call/return prediction. Sits between the fetch address port and the decode/execute redirect paths.

---
 rtl/pc_gen.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/pc_gen.sv
// pc_gen -- fetch-stage program-counter generator.
//
// Registers the next fetch address chosen, highest priority first, from a
// trap, a branch redirect, a redirect held back by a stall, a return-address
// stack prediction, or the sequential successor. Misaligned trap and redirect
// targets are rejected with a one-cycle misaligned pulse.
//
// Ports:
//   clk, rst        clock; asynchronous active-high reset
//   en              advance enable (0 = stall)
//   trap_valid      take trap_vector this cycle, regardless of en
//   trap_vector     trap target
//   redirect_valid  branch/jump resolution redirect
//   redirect_pc     redirect target
//   inst_len16      current instruction is 16-bit (only when COMPRESSED=1)
//   pred_call       current instruction is a call: push return address
//   pred_ret        current instruction is a return: pop and predict
//   pc              current fetch address
//   pc_seq          pc + step, combinational
//   pending         a redirect is latched, waiting for the stall to clear
//   misaligned      one-cycle pulse when a target was rejected
//   ras_count       number of valid return-address stack entries
module pc_gen #(
  parameter int                 XLEN         = 32,
  parameter logic [XLEN-1:0]    RESET_VECTOR = '0,
  parameter int                 RAS_DEPTH    = 4,
  parameter int                 COMPRESSED   = 0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           en,
  input  logic                           trap_valid,
  input  logic [XLEN-1:0]                trap_vector,
  input  logic                           redirect_valid,
  input  logic [XLEN-1:0]                redirect_pc,
  input  logic                           inst_len16,
  input  logic                           pred_call,
  input  logic                           pred_ret,
  output logic [XLEN-1:0]                pc,
  output logic [XLEN-1:0]                pc_seq,
  output logic                           pending,
  output logic                           misaligned,
  output logic [$clog2(RAS_DEPTH):0]     ras_count
);

  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {
    ST_IDLE,
    ST_PEND
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pend_pc_q, pend_pc_d;
  logic            mis_q, mis_d;
  logic [PW-1:0]   ras_ptr_q, ras_ptr_d;   // next write slot; top is ptr-1
  logic [CW-1:0]   ras_cnt_q, ras_cnt_d;

  logic [XLEN-1:0] ras_mem [RAS_DEPTH];
  logic            ras_we;
  logic [PW-1:0]   ras_waddr;
  logic [XLEN-1:0] ras_wdata;

  logic [XLEN-1:0] step;
  logic [PW-1:0]   top_idx;
  logic [XLEN-1:0] ras_top;
  logic            ras_full;

  function automatic logic is_misaligned(input logic [XLEN-1:0] addr);
    return addr[0] | ((COMPRESSED == 0) & addr[1]);
  endfunction

  assign step     = (COMPRESSED != 0 && inst_len16) ? XLEN'(2) : XLEN'(4);
  assign pc_seq   = pc_q + step;              // wraps modulo 2^XLEN
  assign top_idx  = ras_ptr_q - PW'(1);
  assign ras_top  = ras_mem[top_idx];
  assign ras_full = (ras_cnt_q == CW'(RAS_DEPTH));

  // NOTE: every output of this block gets a default first so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    pc_d      = pc_q;
    pend_pc_d = pend_pc_q;
    state_d   = state_q;
    mis_d     = 1'b0;
    ras_ptr_d = ras_ptr_q;
    ras_cnt_d = ras_cnt_q;
    ras_we    = 1'b0;
    ras_waddr = ras_ptr_q;
    ras_wdata = pc_seq;

    if (trap_valid) begin
      // A bad trap target still wins over any redirect; it just isn't taken.
      if (is_misaligned(trap_vector)) begin
        mis_d = 1'b1;
      end else begin
        pc_d    = trap_vector;
        state_d = ST_IDLE;
      end
    end else if (redirect_valid) begin
      if (is_misaligned(redirect_pc)) begin
        mis_d = 1'b1;
      end else if (en) begin
        pc_d    = redirect_pc;
        state_d = ST_IDLE;
      end else begin
        // Newer redirect during the same stall overwrites the latched one.
        pend_pc_d = redirect_pc;
        state_d   = ST_PEND;
      end
    end else if (en) begin
      if (state_q == ST_PEND) begin
        pc_d    = pend_pc_q;
        state_d = ST_IDLE;
      end else if (pred_ret && ras_cnt_q != '0) begin
        pc_d = ras_top;
        if (pred_call) begin
          // Call+return: replace the top in place, depth unchanged.
          ras_we    = 1'b1;
          ras_waddr = top_idx;
        end else begin
          ras_ptr_d = top_idx;
          ras_cnt_d = ras_cnt_q - CW'(1);
        end
      end else begin
        pc_d = pc_seq;
        if (pred_call) begin
          // Circular buffer: when full the push lands on the oldest entry.
          ras_we    = 1'b1;
          ras_ptr_d = ras_ptr_q + PW'(1);
          if (!ras_full) ras_cnt_d = ras_cnt_q + CW'(1);
        end
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values computed by the combinational block.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q      <= RESET_VECTOR;
      pend_pc_q <= '0;
      state_q   <= ST_IDLE;
      mis_q     <= 1'b0;
      ras_ptr_q <= '0;
      ras_cnt_q <= '0;
    end else begin
      pc_q      <= pc_d;
      pend_pc_q <= pend_pc_d;
      state_q   <= state_d;
      mis_q     <= mis_d;
      ras_ptr_q <= ras_ptr_d;
      ras_cnt_q <= ras_cnt_d;
    end
  end

  // NOTE: the stack storage is deliberately not reset; ras_count=0 marks all
  // entries invalid, so clearing them would only add reset fan-out.
  always_ff @(posedge clk) begin
    if (ras_we) ras_mem[ras_waddr] <= ras_wdata;
  end

  assign pc         = pc_q;
  assign pending    = (state_q == ST_PEND);
  assign misaligned = mis_q;
  assign ras_count  = ras_cnt_q;

endmodule
